// File: rtl/vga_scan_ctrl_pkg.sv
// Shared display constants for the VGA scan path: default 640x480@60 timing,
// counter/address width and colour depth.
package vga_scan_ctrl_pkg;

  localparam int unsigned VGA_H_DISP  = 640;
  localparam int unsigned VGA_H_FRONT = 16;
  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_H_BACK  = 48;
  localparam int unsigned VGA_V_DISP  = 480;
  localparam int unsigned VGA_V_FRONT = 10;
  localparam int unsigned VGA_V_SYNC  = 2;
  localparam int unsigned VGA_V_BACK  = 33;
  localparam int unsigned VGA_LAYERS  = 4;

  localparam int unsigned H_DISP_LEN      = 10;
  localparam int unsigned COLOR_RGB_DEPTH = 12;

  typedef logic [H_DISP_LEN-1:0] cnt_t;

  function automatic cnt_t to_cnt(input int unsigned val);
    return cnt_t'(val);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters with enable hold, plus raw (undelayed)
// active, hsync and vsync flags; all flags are forced inactive while en_i is low.
module vga_sync_counter
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned H_DISP  = VGA_H_DISP,
  parameter int unsigned H_FRONT = VGA_H_FRONT,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BACK  = VGA_H_BACK,
  parameter int unsigned V_DISP  = VGA_V_DISP,
  parameter int unsigned V_FRONT = VGA_V_FRONT,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BACK  = VGA_V_BACK
) (
  input  logic                  clk_vga,
  input  logic                  rst_n,
  input  logic                  en_i,
  output logic [H_DISP_LEN-1:0] h_cnt_o,
  output logic [H_DISP_LEN-1:0] v_cnt_o,
  output logic                  active_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);

  localparam cnt_t H_ACT  = to_cnt(H_DISP);
  localparam cnt_t HS_BEG = to_cnt(H_DISP + H_FRONT);
  localparam cnt_t HS_END = to_cnt(H_DISP + H_FRONT + H_SYNC);
  localparam cnt_t H_LAST = to_cnt(H_DISP + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_ACT  = to_cnt(V_DISP);
  localparam cnt_t VS_BEG = to_cnt(V_DISP + V_FRONT);
  localparam cnt_t VS_END = to_cnt(V_DISP + V_FRONT + V_SYNC);
  localparam cnt_t V_LAST = to_cnt(V_DISP + V_FRONT + V_SYNC + V_BACK - 1);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end else begin
      h_cnt_d = h_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign active_o = en_i && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o  = !(en_i && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vsync_o  = !(en_i && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: issues pixel requests to the sprite layers, composites
// their replies over the background and drives the pins two cycles after the request.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned H_DISP  = VGA_H_DISP,
  parameter int unsigned H_FRONT = VGA_H_FRONT,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BACK  = VGA_H_BACK,
  parameter int unsigned V_DISP  = VGA_V_DISP,
  parameter int unsigned V_FRONT = VGA_V_FRONT,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BACK  = VGA_V_BACK,
  parameter int unsigned LAYERS  = VGA_LAYERS,
  parameter int unsigned RGB_W   = COLOR_RGB_DEPTH
) (
  input  logic                    clk_vga,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [LAYERS-1:0]       layer_alpha_i,
  input  logic [LAYERS*RGB_W-1:0] layer_rgb_i,
  input  logic [RGB_W-1:0]        bg_rgb_i,
  output logic [H_DISP_LEN-1:0]   req_x_addr_o,
  output logic [H_DISP_LEN-1:0]   req_y_addr_o,
  output logic                    v_sync_o,
  output logic                    h_sync_o,
  output logic                    vga_v_sync_o,
  output logic [RGB_W-1:0]        vga_rgb_o,
  output logic                    frame_start_o
);

  cnt_t h_cnt, v_cnt;
  logic active, hsync, vsync;

  vga_sync_counter #(
    .H_DISP (H_DISP),  .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP (V_DISP),  .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_cnt (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .active_o(active),
    .hsync_o (hsync),
    .vsync_o (vsync)
  );

  // All-ones outside the active area so no sprite matches and BRAMs hold.
  assign req_x_addr_o  = active ? h_cnt : '1;
  assign req_y_addr_o  = active ? v_cnt : '1;
  assign v_sync_o      = vsync;
  assign frame_start_o = en_i && (h_cnt == '0) && (v_cnt == '0);

  logic             act_q, act_d;
  logic [1:0]       hs_q, hs_d;
  logic [1:0]       vs_q, vs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  // Walk from lowest priority up so the lowest-index opaque layer wins.
  always_comb begin
    act_d = active;
    hs_d  = {hs_q[0], hsync};
    vs_d  = {vs_q[0], vsync};
    rgb_d = bg_rgb_i;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (layer_alpha_i[k]) rgb_d = layer_rgb_i[k*RGB_W +: RGB_W];
    end
    if (!act_q) rgb_d = '0;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      hs_q  <= 2'b11;
      vs_q  <= 2'b11;
      rgb_q <= '0;
    end else begin
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign h_sync_o     = hs_q[1];
  assign vga_v_sync_o = vs_q[1];
  assign vga_rgb_o    = rgb_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomised bench for vga_scan_ctrl against a position-based reference model;
// vertical timing is shortened so whole frames fit in a short run.
module tb_vga_scan_ctrl;

  localparam int H_TOT   = 800;
  localparam int H_ACT   = 640;
  localparam int HS_BEG  = 656;
  localparam int HS_END  = 752;
  localparam int TV_DISP = 8;
  localparam int TV_FRNT = 2;
  localparam int TV_SYNC = 2;
  localparam int TV_BACK = 3;
  localparam int FRAME   = H_TOT * (TV_DISP + TV_FRNT + TV_SYNC + TV_BACK);

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic [3:0]  layer_alpha_i;
  logic [47:0] layer_rgb_i;
  logic [11:0] bg_rgb_i;
  logic [9:0]  req_x_addr_o, req_y_addr_o;
  logic        v_sync_o, h_sync_o, vga_v_sync_o, frame_start_o;
  logic [11:0] vga_rgb_o;

  vga_scan_ctrl #(
    .V_DISP(TV_DISP), .V_FRONT(TV_FRNT), .V_SYNC(TV_SYNC), .V_BACK(TV_BACK)
  ) dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .layer_alpha_i(layer_alpha_i),
    .layer_rgb_i  (layer_rgb_i),
    .bg_rgb_i     (bg_rgb_i),
    .req_x_addr_o (req_x_addr_o),
    .req_y_addr_o (req_y_addr_o),
    .v_sync_o     (v_sync_o),
    .h_sync_o     (h_sync_o),
    .vga_v_sync_o (vga_v_sync_o),
    .vga_rgb_o    (vga_rgb_o),
    .frame_start_o(frame_start_o)
  );

  always #20 clk_vga = ~clk_vga;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position plus what the pins should show now.
  int          pos;
  bit          m_act1;
  logic [11:0] m_c1;
  bit          m_hs1, m_hs2, m_vs1, m_vs2;
  bit          en_req, rst_req, track;
  int          gcyc = 0, last_fs = -1, vs_cnt = 0, vs_first = -1;

  function automatic logic [11:0] winner(input logic [3:0] a, input logic [47:0] rgb,
                                         input logic [11:0] bg);
    for (int k = 0; k < 4; k++) if (a[k]) return rgb[k*12 +: 12];
    return bg;
  endfunction

  task automatic model_reset();
    pos = 0; m_act1 = 0; m_c1 = '0;
    m_hs1 = 1; m_hs2 = 1; m_vs1 = 1; m_vs2 = 1;
  endtask

  task automatic drive_inputs();
    int h, v;
    rst_n = rst_req;
    en_i  = en_req;
    h = pos % H_TOT;
    v = pos / H_TOT;
    layer_alpha_i = 4'($urandom);
    layer_rgb_i   = 48'({$urandom, $urandom});
    bg_rgb_i      = 12'($urandom_range(1, 4095));
    if (!m_act1) layer_alpha_i = 4'hF;
    if (v == 4 && h >= 380 && h <= 420) layer_alpha_i = 4'h0;
    if (h == 11 && v >= 5 && v <= 7) begin
      bg_rgb_i = 12'h111;
      layer_rgb_i[12 +: 12] = 12'hF00;
      layer_rgb_i[24 +: 12] = 12'h0F0;
      layer_alpha_i = (v == 5) ? 4'b0110 : (v == 6) ? 4'b0100 : 4'b0000;
    end
  endtask

  task automatic check_and_advance();
    int h, v;
    bit act, hs, vs;
    logic [11:0] comp;
    h   = pos % H_TOT;
    v   = pos / H_TOT;
    act = en_i && h < H_ACT && v < TV_DISP;
    hs  = !(en_i && h >= HS_BEG && h < HS_END);
    vs  = !(en_i && v >= TV_DISP + TV_FRNT && v < TV_DISP + TV_FRNT + TV_SYNC);
    check("req_x", req_x_addr_o, act ? h : 1023);
    check("req_y", req_y_addr_o, act ? v : 1023);
    check("v_sync_req", v_sync_o, vs);
    check("frame_start", frame_start_o, en_i && pos == 0);
    check("rgb", vga_rgb_o, m_c1);
    check("h_sync", h_sync_o, m_hs2);
    check("vga_v_sync", vga_v_sync_o, m_vs2);
    if (rst_n && en_i) begin
      if (h == 657) check("hs_pre", h_sync_o, 1);
      if (h == 658) check("hs_fall", h_sync_o, 0);
      if (h == 753) check("hs_last", h_sync_o, 0);
      if (h == 754) check("hs_rise", h_sync_o, 1);
      if (pos == 5*H_TOT + 12) check("comp_l1", vga_rgb_o, 12'hF00);
      if (pos == 6*H_TOT + 12) check("comp_l2", vga_rgb_o, 12'h0F0);
      if (pos == 7*H_TOT + 12) check("comp_bg", vga_rgb_o, 12'h111);
    end
    gcyc++;
    if (track && rst_n) begin
      if (last_fs >= 0 && !vga_v_sync_o) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = gcyc - last_fs;
      end
      if (frame_start_o) begin
        if (last_fs >= 0) begin
          check("fs_period", gcyc - last_fs, FRAME);
          check("vs_low_cnt", vs_cnt, 2 * H_TOT);
          check("vs_start", vs_first, (TV_DISP + TV_FRNT) * H_TOT + 2);
        end
        last_fs = gcyc; vs_cnt = 0; vs_first = -1;
      end
    end
    comp = m_act1 ? winner(layer_alpha_i, layer_rgb_i, bg_rgb_i) : 12'h000;
    if (rst_n) begin
      m_c1 = comp; m_act1 = act;
      m_hs2 = m_hs1; m_hs1 = hs;
      m_vs2 = m_vs1; m_vs1 = vs;
      pos = en_i ? (pos + 1) % FRAME : 0;
    end else begin
      model_reset();
    end
  endtask

  task automatic one_cycle();
    @(posedge clk_vga);
    #1 drive_inputs();
    @(negedge clk_vga);
    check_and_advance();
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (pos != target && guard < FRAME + 10) begin
      one_cycle();
      guard++;
    end
    check("run_to_reached", pos, target);
  endtask

  initial begin
    #2400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en_i = 1'b0; layer_alpha_i = '0; layer_rgb_i = '0; bg_rgb_i = '0;
    rst_req = 0; en_req = 0; track = 0;
    model_reset();
    repeat (3) one_cycle();
    check("rst_rgb", vga_rgb_o, 0);
    check("rst_hs", h_sync_o, 1);
    check("rst_vs", vga_v_sync_o, 1);
    check("rst_req_x", req_x_addr_o, 10'h3FF);

    en_req = 1;
    one_cycle();
    track = 1; rst_req = 1;
    repeat (2 * FRAME + 10) one_cycle();
    track = 0;

    run_to(3*H_TOT + 300);
    en_req = 0;
    one_cycle();
    check("dis_req_x", req_x_addr_o, 10'h3FF);
    check("dis_req_y", req_y_addr_o, 10'h3FF);
    check("dis_fs", frame_start_o, 0);
    repeat (2) one_cycle();
    check("dis_rgb", vga_rgb_o, 0);
    check("dis_hs", h_sync_o, 1);
    check("dis_vs", vga_v_sync_o, 1);
    repeat (3) one_cycle();
    en_req = 1;
    one_cycle();
    check("reen_fs", frame_start_o, 1);
    check("reen_req_x", req_x_addr_o, 0);

    run_to(4*H_TOT + 400);
    @(posedge clk_vga);
    #1 drive_inputs();
    #2 rst_req = 0; rst_n = 1'b0;
    #1;
    check("arst_rgb", vga_rgb_o, 0);
    check("arst_hs", h_sync_o, 1);
    check("arst_vs", vga_v_sync_o, 1);
    check("arst_req_x", req_x_addr_o, 0);
    check("arst_req_y", req_y_addr_o, 0);
    model_reset();
    @(negedge clk_vga);
    check_and_advance();
    repeat (2) one_cycle();
    rst_req = 1;
    one_cycle();
    check("restart_x", req_x_addr_o, 0);
    check("restart_y", req_y_addr_o, 0);
    repeat (1700) one_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
Display-side initiator of the sprite pixel-request interface. It generates 640x480@60 VGA timing, issues req_x_addr/req_y_addr/v_sync to all sprite layers (enemies, player, bullets), collects their alpha/rgb replies and composites them over the background. It drives the VGA pins with a fixed pipeline latency. One instance sits at the top level between the sprite layers and the VGA connector.

Parameters:
H_DISP, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync pulse width
H_BACK, 48, horizontal back porch
V_DISP, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width
V_BACK, 33, vertical back porch
LAYERS, 4, number of sprite layers; layer 0 has the highest priority
RGB_W, 12, `COLOR_RGB_DEPTH

Ports:
clk_vga  in  1  pixel clock (25 MHz)
rst_n  in  1  reset; asynchronous, active-low
en_i  in  1  scan enable; low = blank screen, counters held at 0
layer_alpha_i  in  LAYERS  per-layer opaque flag, valid the cycle after the request
layer_rgb_i  in  LAYERS*RGB_W  per-layer colour; layer k occupies bits [k*RGB_W +: RGB_W]
bg_rgb_i  in  RGB_W  background colour, same timing as the layers
req_x_addr_o  out  `H_DISP_LEN  requested pixel x; all-ones outside the active area
req_y_addr_o  out  `H_DISP_LEN  requested pixel y; all-ones outside the active area
v_sync_o  out  1  request-side vsync to sprites; active-low, aligned with the request counters
h_sync_o  out  1  VGA HS pin; active-low
vga_v_sync_o  out  1  VGA VS pin; active-low
vga_rgb_o  out  RGB_W  VGA colour pins
frame_start_o  out  1  one-cycle pulse when the request counters are at (0,0)

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1 (H_TOTAL = 800); v_cnt runs 0..V_TOTAL-1 (V_TOTAL = 525) and increments when h_cnt wraps. Both counters are 10 bits. v_cnt wraps to 0 after 524.
- Request stage S0, combinational from the counters:
  - req_x = h_cnt and req_y = v_cnt when h_cnt<H_DISP and v_cnt<V_DISP; otherwise both are all-ones, so no sprite matches and sprite BRAM addresses do not advance.
  - v_sync_o = 0 when V_DISP+V_FRONT <= v_cnt < V_DISP+V_FRONT+V_SYNC, else 1.
  - frame_start_o = 1 iff h_cnt==0, v_cnt==0 and en_i.
- Reply stage S1: sprites return alpha/rgb one cycle after S0 (BRAM read latency). Composite:
  - use the lowest-index layer k with alpha[k]=1; if none is set, use bg_rgb_i;
  - force 0 if the delayed active flag is 0.
- Output stage S2: vga_rgb_o is registered, so it appears 2 cycles after the S0 request.
- h_sync (low when H_DISP+H_FRONT <= h_cnt < H_DISP+H_FRONT+H_SYNC), the vertical sync and the active flag are delayed through a 2-stage shift register, so the pins stay aligned with vga_rgb_o.
- en_i low: h_cnt and v_cnt held at 0, req_* all-ones, v_sync_o=1, frame_start_o=0. Pipeline continues flushing, so vga_rgb_o reaches 0 and syncs reach 1 within 2 cycles. en_i rising: scan starts at (0,0) on the next edge.
- Reset values: h_cnt=v_cnt=0, all pipeline registers cleared, vga_rgb_o=0, h_sync_o=1, vga_v_sync_o=1. Reset mid-frame restarts at (0,0) with no partial-line recovery.
- Simultaneous alphas: strict priority, no blending. Alpha or rgb values outside the active area are ignored.

Decomposition:
- Timing constants (H_/V_ porch/sync/total, H_DISP_LEN, COLOR_RGB_DEPTH) belong in the shared define header next to the existing display constants.
- Sub-module vga_sync_counter: h_cnt/v_cnt, wrap logic and en_i hold. It outputs the counters plus raw active/hsync/vsync flags.
- Compositing and the delay pipeline stay in vga_scan_ctrl.

Test Plan:
- Reset then en_i=1: frame_start_o pulses every 420000 cycles. Between pulses there are exactly 2*800 cycles of vga_v_sync_o low, starting 490*800+2 cycles after frame_start.
- Line timing: h_sync_o goes low at output cycle 658 (656+2) of each line for exactly 96 cycles. req_x_addr_o runs 0..639, then all-ones for 160 cycles.
- Composite: bg=12'h111, layer1 alpha=1 rgb=12'hF00, layer2 alpha=1 rgb=12'h0F0 at request (10,5) -> vga_rgb_o=12'hF00 two cycles later. Dropping layer1 alpha -> 12'h0F0; no alpha -> 12'h111.
- Blanking: layer alpha forced 1 during the porches -> vga_rgb_o stays 0 for all non-active cycles.
- en_i deasserted at (300,200): req_* all-ones next cycle, vga_rgb_o=0 and syncs=1 within 2 cycles. Re-enable -> frame_start_o on the following edge.
- rst_n pulled low asynchronously mid-line at (400,100) -> outputs reach reset values without a clock edge. After release, the counters restart at (0,0).
